// File: rtl/result_serializer.sv
// Byte serializer for upstream result words: accepts one WIDTH-bit word per
// handshake, streams it MSB byte first, and tracks matches against EXPECTED.
module result_serializer #(
    parameter int                WIDTH    = 24,
    parameter logic [WIDTH-1:0]  EXPECTED = 24'hC0FFEE,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              mismatch,
    output logic              busy
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mism_q, mism_d;
    logic [WIDTH-1:0]   aligned;

    // Shifting left by 8*idx brings the byte being sent into the top byte lane.
    assign aligned = word_q << {idx_q, 3'b000};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        mism_d    = mism_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 8'h00;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = SEND;
                    if (in_data == EXPECTED) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        mism_d = 1'b1;
                    end
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = aligned[WIDTH-1 -: 8];
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) state_d = IDLE;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
        end
    end

    assign match_cnt = cnt_q;
    assign mismatch  = mism_q;

endmodule
